// File: rtl/branch_reservation_station.sv
// Reservation station for branch, JAL and JALR instructions. Entries wait
// for both source operands (captured at dispatch or snooped off the CDB),
// and the oldest ready entry is moved into a registered issue slot that
// feeds the branch ALU. A flush drops every pending entry.
module branch_reservation_station #(
    parameter int WIDTH   = 31,
    parameter int C_WIDTH = 7,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               dispatchValid,
    input  logic               dispatchRdy1,
    input  logic               dispatchRdy2,
    input  logic [TAG_W-1:0]   dispatchTag1,
    input  logic [TAG_W-1:0]   dispatchTag2,
    input  logic [WIDTH:0]     dispatchVal1,
    input  logic [WIDTH:0]     dispatchVal2,
    input  logic [WIDTH:0]     dispatchPC,
    input  logic [WIDTH:0]     dispatchImm,
    input  logic [WIDTH:0]     dispatchPredPC,
    input  logic [C_WIDTH:0]   dispatchControl,
    input  logic [TAG_W-1:0]   dispatchRobTag,
    input  logic               cdbValid,
    input  logic [TAG_W-1:0]   cdbTag,
    input  logic [WIDTH:0]     cdbValue,
    input  logic               issueReady,
    output logic               rsFull,
    output logic               issueValid,
    output logic [WIDTH:0]     src1,
    output logic [WIDTH:0]     src2,
    output logic [WIDTH:0]     PC,
    output logic [WIDTH:0]     immExt,
    output logic [WIDTH:0]     predictedPC,
    output logic [C_WIDTH:0]   branchControl,
    output logic [TAG_W-1:0]   issueRobTag
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // entry storage
    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   rdy1_q;
    logic [DEPTH-1:0]   rdy2_q;
    logic [TAG_W-1:0]   tag1_q   [DEPTH];
    logic [TAG_W-1:0]   tag2_q   [DEPTH];
    logic [WIDTH:0]     val1_q   [DEPTH];
    logic [WIDTH:0]     val2_q   [DEPTH];
    logic [WIDTH:0]     pc_q     [DEPTH];
    logic [WIDTH:0]     imm_q    [DEPTH];
    logic [WIDTH:0]     pred_q   [DEPTH];
    logic [C_WIDTH:0]   ctrl_q   [DEPTH];
    logic [TAG_W-1:0]   rob_q    [DEPTH];
    logic [AW-1:0]      age_q    [DEPTH];

    // issue register
    logic               issue_valid_q;
    logic [WIDTH:0]     src1_q;
    logic [WIDTH:0]     src2_q;
    logic [WIDTH:0]     pc_out_q;
    logic [WIDTH:0]     imm_out_q;
    logic [WIDTH:0]     pred_out_q;
    logic [C_WIDTH:0]   ctrl_out_q;
    logic [TAG_W-1:0]   rob_out_q;
    logic               rs_full_q;

    logic               sel_found;
    logic [AW-1:0]      sel_idx;
    logic [AW-1:0]      sel_age;
    logic               alloc_found;
    logic [AW-1:0]      alloc_idx;
    logic               issue_load;
    logic               disp_accept;
    logic               byp1;
    logic               byp2;
    logic [DEPTH-1:0]   wake1;
    logic [DEPTH-1:0]   wake2;
    logic [DEPTH-1:0]   free_mask;
    logic [DEPTH-1:0]   alloc_mask;
    logic [DEPTH-1:0]   valid_d;
    logic [AW-1:0]      age_inc;

    // Oldest-ready select: among entries with both operands, largest age wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && rdy1_q[i] && rdy2_q[i] &&
                (!sel_found || (age_q[i] > sel_age))) begin
                sel_found = 1'b1;
                sel_idx   = AW'(i);
                sel_age   = age_q[i];
            end
        end
    end

    // Lowest free slot, taken from the occupancy before this edge so a slot
    // freed by issue in the same cycle is not reused until the next one.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = AW'(i);
            end
        end
    end

    assign issue_load  = (!issue_valid_q || issueReady) && sel_found;
    assign disp_accept = dispatchValid && !rs_full_q && alloc_found;
    assign byp1        = !dispatchRdy1 && cdbValid && (cdbTag == dispatchTag1);
    assign byp2        = !dispatchRdy2 && cdbValid && (cdbTag == dispatchTag2);
    assign age_inc     = disp_accept ? AW'(1) : '0;

    // Per-entry wakeup matches, allocation/free masks and next occupancy.
    always_comb begin
        free_mask  = '0;
        alloc_mask = '0;
        wake1      = '0;
        wake2      = '0;
        if (issue_load)  free_mask[sel_idx]    = 1'b1;
        if (disp_accept) alloc_mask[alloc_idx] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = cdbValid && !rdy1_q[i] && (tag1_q[i] == cdbTag);
            wake2[i] = cdbValid && !rdy2_q[i] && (tag2_q[i] == cdbTag);
        end
        valid_d = (valid_q & ~free_mask) | alloc_mask;
    end

    // Entry state. Ages are kept as a dense rank among occupied entries:
    // each dispatch ages everyone, and an issue pulls the entries older than
    // the issued one down by one, so a long-waiting entry never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag1_q[i] <= '0;
                tag2_q[i] <= '0;
                val1_q[i] <= '0;
                val2_q[i] <= '0;
                pc_q[i]   <= '0;
                imm_q[i]  <= '0;
                pred_q[i] <= '0;
                ctrl_q[i] <= '0;
                rob_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_mask[i]) begin
                    rdy1_q[i] <= dispatchRdy1 | byp1;
                    rdy2_q[i] <= dispatchRdy2 | byp2;
                    tag1_q[i] <= dispatchTag1;
                    tag2_q[i] <= dispatchTag2;
                    val1_q[i] <= byp1 ? cdbValue : dispatchVal1;
                    val2_q[i] <= byp2 ? cdbValue : dispatchVal2;
                    pc_q[i]   <= dispatchPC;
                    imm_q[i]  <= dispatchImm;
                    pred_q[i] <= dispatchPredPC;
                    ctrl_q[i] <= dispatchControl;
                    rob_q[i]  <= dispatchRobTag;
                    age_q[i]  <= '0;
                end else if (valid_q[i]) begin
                    if (wake1[i]) begin
                        rdy1_q[i] <= 1'b1;
                        val1_q[i] <= cdbValue;
                    end
                    if (wake2[i]) begin
                        rdy2_q[i] <= 1'b1;
                        val2_q[i] <= cdbValue;
                    end
                    if (issue_load && (age_q[i] > sel_age)) begin
                        age_q[i] <= age_q[i] + age_inc - AW'(1);
                    end else begin
                        age_q[i] <= age_q[i] + age_inc;
                    end
                end
            end
        end
    end

    // Issue slot: load the selected entry when empty or being drained,
    // otherwise hold steady while the ALU path stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_valid_q <= 1'b0;
            src1_q        <= '0;
            src2_q        <= '0;
            pc_out_q      <= '0;
            imm_out_q     <= '0;
            pred_out_q    <= '0;
            ctrl_out_q    <= '0;
            rob_out_q     <= '0;
        end else if (flush) begin
            issue_valid_q <= 1'b0;
        end else if (issue_load) begin
            issue_valid_q <= 1'b1;
            src1_q        <= val1_q[sel_idx];
            src2_q        <= val2_q[sel_idx];
            pc_out_q      <= pc_q[sel_idx];
            imm_out_q     <= imm_q[sel_idx];
            pred_out_q    <= pred_q[sel_idx];
            ctrl_out_q    <= ctrl_q[sel_idx];
            rob_out_q     <= rob_q[sel_idx];
        end else if (issueReady) begin
            issue_valid_q <= 1'b0;
        end
    end

    // Full flag reflects occupancy after this edge's dispatch and free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_full_q <= 1'b0;
        end else if (flush) begin
            rs_full_q <= 1'b0;
        end else begin
            rs_full_q <= &valid_d;
        end
    end

    assign rsFull        = rs_full_q;
    assign issueValid    = issue_valid_q;
    assign src1          = src1_q;
    assign src2          = src2_q;
    assign PC            = pc_out_q;
    assign immExt        = imm_out_q;
    assign predictedPC   = pred_out_q;
    assign branchControl = ctrl_out_q;
    assign issueRobTag   = rob_out_q;

endmodule

// File: doc/branch_reservation_station.md
Name: branch_reservation_station

Overview:
- Holds dispatched branch, JAL and JALR instructions until both source operands are available.
- Snoops the common data bus (CDB) for the operands an entry is still waiting on.
- Issues the oldest ready entry through a registered output to the branch ALU.
- Sits between dispatch/rename and the branch ALU, and is cleared on pipeline flush after a mispredict.

Parameters:
WIDTH, 31, MSB index of data/address buses (bus is WIDTH+1 bits)
C_WIDTH, 7, MSB index of branchControl ({isJAL,isJALR,funct3,state[1:0],redirect})
DEPTH, 4, number of entries (power of 2, >=2)
TAG_W, 4, ROB tag width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of all state (mispredict/misdirect recovery)
dispatchValid  in  1  dispatch request this cycle
dispatchRdy1  in  1  src1 value present at dispatch
dispatchRdy2  in  1  src2 value present at dispatch
dispatchTag1  in  TAG_W  producer ROB tag of src1 when not ready
dispatchTag2  in  TAG_W  producer ROB tag of src2 when not ready
dispatchVal1  in  WIDTH+1  src1 value when ready
dispatchVal2  in  WIDTH+1  src2 value when ready
dispatchPC  in  WIDTH+1  instruction PC
dispatchImm  in  WIDTH+1  sign-extended immediate
dispatchPredPC  in  WIDTH+1  predicted target from BTB
dispatchControl  in  C_WIDTH+1  branch control vector
dispatchRobTag  in  TAG_W  ROB tag of this instruction
cdbValid  in  1  CDB broadcast valid
cdbTag  in  TAG_W  ROB tag of broadcast result
cdbValue  in  WIDTH+1  broadcast result value
issueReady  in  1  branch ALU path accepts the issued instruction
rsFull  out  1  all DEPTH entries occupied
issueValid  out  1  issue register holds a valid instruction
src1  out  WIDTH+1  issued src1
src2  out  WIDTH+1  issued src2
PC  out  WIDTH+1  issued PC
immExt  out  WIDTH+1  issued immediate
predictedPC  out  WIDTH+1  issued predicted PC
branchControl  out  C_WIDTH+1  issued control vector
issueRobTag  out  TAG_W  issued ROB tag

Behaviour:
- Reset (reset=0, asynchronous):
  - All entry valid bits, ages and ready bits are 0.
  - issueValid=0, rsFull=0; all data outputs are 0.
- Entry contents: valid, rdy1, rdy2, tag1, tag2, val1, val2, PC, imm, predPC, control, robTag, age (log2(DEPTH) bits).
- Dispatch:
  - When dispatchValid && !rsFull && !flush, the lowest-index free entry is written at the clock edge.
  - Dispatch while rsFull is ignored; no entry changes.
- Dispatch-cycle CDB bypass: if a source is not ready at dispatch and cdbValid && cdbTag matches its dispatch tag in the same cycle, the entry stores cdbValue with ready=1.
- Wakeup: each valid entry with rdyN=0 and tagN==cdbTag while cdbValid captures cdbValue into valN and sets rdyN=1 at the edge. Both sources may wake on the same broadcast.
- Age:
  - A newly dispatched entry gets age 0.
  - On every accepted dispatch, all other valid entries increment their age.
  - Ages of valid entries are unique; no saturation is needed because occupancy is at most DEPTH.
- Select (combinational):
  - Candidate = valid && rdy1 && rdy2.
  - Pick the candidate with the largest age (oldest).
- Issue register:
  - Loads when (!issueValid || issueReady) and a candidate exists.
  - On load, the selected entry's fields are copied, the entry is freed, and issueValid=1 next cycle.
  - If issueValid && !issueReady, the register holds all outputs stable and no entry is freed.
  - If issueValid && issueReady and there is no candidate, issueValid=0 next cycle.
- Latency:
  - Dispatch with both sources ready in cycle 0 gives issueValid=1 in cycle 2.
  - CDB wakeup of the last source in cycle c gives issueValid=1 in cycle c+2.
- Same-cycle dispatch and issue-free: the freed entry is not reused that cycle. Allocation uses the free set before this edge.
- rsFull is registered. It equals 1 when all entries are valid after the edge, counting dispatch and free in that same edge.
- Flush:
  - Has priority over dispatch, wakeup and issue.
  - At the edge, clears all valid bits and ages, and sets issueValid=0.
  - Outputs hold their values but are invalid.
- Reset asserted mid-operation: immediately returns to the reset state, including an instruction held in the issue register.

Test Plan:
- Reset, then dispatch BEQ with rdy1=rdy2=1, val1=val2=5, robTag=3, issueReady=1 -> issueValid=1 in cycle 2, src1=src2=5, issueRobTag=3; rsFull=0.
- Dispatch with rdy2=0, tag2=7; cdbValid with tag 7, value 0x10 in cycle 4 -> src2=0x10, issueValid=1 in cycle 6; no issue before.
- Dispatch 4 entries with tags pending, then a 5th dispatch -> rsFull=1 and the 5th is ignored; wake all in one broadcast -> issue order by robTag equals dispatch order.
- Dispatch with tag1=2 while cdbValid, cdbTag=2, cdbValue=9 in the same cycle -> entry ready, src1=9 issued in cycle 2.
- issueReady=0 for 3 cycles with issueValid=1 -> outputs stable, entries retained; issueReady=1 -> next-oldest entry issued the following cycle.
- Fill 3 entries, assert flush with dispatchValid=1 -> issueValid=0, rsFull=0, next cycle no entries valid; the dispatch in the flush cycle is dropped.
